// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, default colours and direction encoding for pong_engine.
package pong_pkg;

  typedef enum logic [2:0] {
    CLEAR      = 3'd0,
    DRAW       = 3'd1,
    WAIT_START = 3'd2,
    WAIT_TICK  = 3'd3,
    ERASE      = 3'd4,
    UPDATE     = 3'd5,
    LOST       = 3'd6
  } state_e;

  localparam logic [2:0] COL_BG   = 3'b001;
  localparam logic [2:0] COL_PAD  = 3'b010;
  localparam logic [2:0] COL_BALL = 3'b111;
  localparam logic [2:0] COL_LOST = 3'b100;

  // One-bit direction: 1 moves towards larger coordinates
  typedef logic dir_t;
  localparam dir_t DIR_INC = 1'b1;
  localparam dir_t DIR_DEC = 1'b0;

  function automatic dir_t dir_flip(input dir_t d);
    return (d == DIR_INC) ? DIR_DEC : DIR_INC;
  endfunction

endpackage

// File: rtl/pong_engine_if.sv
// pong_engine_if: framebuffer write port; the engine drives it as master, the RAM side listens as slave.
interface pong_engine_if #(
  parameter int AW = 15,
  parameter int DW = 3
);
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr;

  modport master (output mem_px_addr, output mem_px_data, output px_wr);
  modport slave  (input  mem_px_addr, input  mem_px_data, input  px_wr);
endinterface

// File: rtl/pong_tick_gen.sv
// pong_tick_gen: enabled modulo-period counter emitting a one-cycle tick at the terminal count.
module pong_tick_gen #(
  parameter int TW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [TW-1:0] period_i,
  output logic          tick_o
);
  logic [TW-1:0] cnt_q, cnt_d;
  logic          tick_s;

  // Terminal-count decode; >= covers a period that shrinks below the running count
  always_comb begin
    tick_s = en_i && (cnt_q >= (period_i - TW'(1'b1)));
    if (!en_i) begin
      cnt_d = {TW{1'b0}};
    end else if (tick_s) begin
      cnt_d = {TW{1'b0}};
    end else begin
      cnt_d = cnt_q + TW'(1'b1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {TW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = tick_s;
endmodule

// File: rtl/pong_engine.sv
// pong_engine: single-paddle ball game rendering into a framebuffer, at most one pixel write per clock.
// Optional feature macro PONG_SCORE_EN adds a bounce score output and a per-bounce speed-up.
module pong_engine
  import pong_pkg::*;
#(
  parameter int AW       = 15,
  parameter int DW       = 3,
  parameter int SCR_W    = 128,
  parameter int SCR_H    = 96,
  parameter int PAD_W    = 3,
  parameter int PAD_Y    = 80,
  parameter int TICK_DIV = 250000,
  parameter logic [DW-1:0] C_BG   = DW'(COL_BG),
  parameter logic [DW-1:0] C_PAD  = DW'(COL_PAD),
  parameter logic [DW-1:0] C_BALL = DW'(COL_BALL),
  parameter logic [DW-1:0] C_LOST = DW'(COL_LOST)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_right,
  input  logic btn_left,
  input  logic btn_start,
  pong_engine_if.master px_if,
  output logic game_over,
  output logic busy
`ifdef PONG_SCORE_EN
  ,
  output logic [7:0] score
`endif
);
  localparam int XW = $clog2(SCR_W);
  localparam int YW = $clog2(SCR_H);
  localparam int TW = $clog2(TICK_DIV + 1);

  localparam logic [XW-1:0] X_ZERO     = XW'(1'b0);
  localparam logic [XW-1:0] X_ONE      = XW'(1'b1);
  localparam logic [XW-1:0] X_MAX      = XW'(SCR_W - 1);
  localparam logic [XW-1:0] X_INIT     = XW'(SCR_W / 2);
  localparam logic [XW-1:0] PAD_MIN    = XW'(PAD_W / 2);
  localparam logic [XW-1:0] PAD_MAX    = XW'(SCR_W - 1 - PAD_W / 2);
  localparam logic [YW-1:0] Y_ZERO     = YW'(1'b0);
  localparam logic [YW-1:0] Y_ONE      = YW'(1'b1);
  localparam logic [YW-1:0] Y_MAX      = YW'(SCR_H - 1);
  localparam logic [YW-1:0] Y_INIT     = YW'(SCR_H / 2);
  localparam logic [YW-1:0] PAD_ROW    = YW'(PAD_Y);
  localparam logic [YW-1:0] BOUNCE_ROW = YW'(PAD_Y - 1);
  localparam logic [AW-1:0] A_ZERO     = AW'(1'b0);
  localparam logic [AW-1:0] A_ONE      = AW'(1'b1);
  localparam logic [AW-1:0] LAST_PIX   = AW'(SCR_W * SCR_H - 1);
  localparam logic [AW-1:0] LAST_SPR   = AW'(PAD_W);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] ball_x_q, ball_x_d, pad_x_q, pad_x_d;
  logic [YW-1:0] ball_y_q, ball_y_d;
  dir_t          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic          started_q, started_d;
  logic          px_wr_q, px_wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          game_over_q, game_over_d;
  logic          busy_q, busy_d;

  logic [XW-1:0] pad_new_s, bx_new_s, dist_s;
  logic [YW-1:0] by_new_s;
  dir_t          dx_s, dy0_s, dy_s;
  logic          hit_s, lose_s;
  logic          tick_en_s, tick_s;
  logic [TW-1:0] period_s;

`ifdef PONG_SCORE_EN
  localparam logic [TW-1:0] PER_INIT  = TW'(TICK_DIV);
  localparam logic [TW-1:0] PER_STEP  = TW'(TICK_DIV / 16);
  localparam logic [TW-1:0] PER_FLOOR = TW'(TICK_DIV / 4);
  logic [7:0]    score_q, score_d;
  logic [TW-1:0] period_q, period_d;
  assign period_s = period_q;
  assign score    = score_q;
`else
  assign period_s = TW'(TICK_DIV);
`endif

  function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * AW'(SCR_W) + AW'(x);
  endfunction

  function automatic logic [XW-1:0] pad_px(input logic [XW-1:0] pad, input logic [AW-1:0] k);
    return pad - PAD_MIN + XW'(k);
  endfunction

  assign tick_en_s = (state_q == WAIT_TICK);

  pong_tick_gen #(.TW(TW)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .en_i     (tick_en_s),
    .period_i (period_s),
    .tick_o   (tick_s)
  );

  // Candidate paddle/ball step; only committed when the FSM is in UPDATE
  always_comb begin
    if (btn_right && !btn_left && (pad_x_q < PAD_MAX)) begin
      pad_new_s = pad_x_q + X_ONE;
    end else if (btn_left && !btn_right && (pad_x_q > PAD_MIN)) begin
      pad_new_s = pad_x_q - X_ONE;
    end else begin
      pad_new_s = pad_x_q;
    end

    if (ball_x_q == X_ZERO) begin
      dx_s = DIR_INC;
    end else if (ball_x_q == X_MAX) begin
      dx_s = DIR_DEC;
    end else begin
      dx_s = dir_x_q;
    end
    bx_new_s = (dx_s == DIR_INC) ? (ball_x_q + X_ONE) : (ball_x_q - X_ONE);

    dy0_s  = (ball_y_q == Y_ZERO) ? DIR_INC : dir_y_q;
    dist_s = (ball_x_q >= pad_new_s) ? (ball_x_q - pad_new_s) : (pad_new_s - ball_x_q);
    hit_s  = (ball_y_q == BOUNCE_ROW) && (dy0_s == DIR_INC) && (dist_s <= PAD_MIN);
    dy_s   = hit_s ? dir_flip(dy0_s) : dy0_s;
    by_new_s = (dy_s == DIR_INC) ? (ball_y_q + Y_ONE) : (ball_y_q - Y_ONE);
    lose_s = (by_new_s == Y_MAX);
  end

  // Next-state and pixel-write decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    pad_x_d     = pad_x_q;
    started_d   = started_q;
    px_wr_d     = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    game_over_d = game_over_q;
    busy_d      = busy_q;
`ifdef PONG_SCORE_EN
    score_d     = score_q;
    period_d    = period_q;
`endif

    case (state_q)
      CLEAR: begin
        px_wr_d = 1'b1;
        addr_d  = cnt_q;
        data_d  = C_BG;
        busy_d  = 1'b1;
        if (cnt_q == LAST_PIX) begin
          cnt_d   = A_ZERO;
          busy_d  = 1'b0;
          state_d = DRAW;
        end else begin
          cnt_d = cnt_q + A_ONE;
        end
      end
      DRAW: begin
        px_wr_d = 1'b1;
        if (cnt_q < LAST_SPR) begin
          addr_d = pix_addr(pad_px(pad_x_q, cnt_q), PAD_ROW);
          data_d = C_PAD;
        end else begin
          addr_d = pix_addr(ball_x_q, ball_y_q);
          data_d = C_BALL;
        end
        if (cnt_q == LAST_SPR) begin
          cnt_d   = A_ZERO;
          state_d = started_q ? WAIT_TICK : WAIT_START;
        end else begin
          cnt_d = cnt_q + A_ONE;
        end
      end
      WAIT_START: begin
        if (btn_start) begin
          started_d = 1'b1;
          state_d   = WAIT_TICK;
        end else begin
          state_d = WAIT_START;
        end
      end
      WAIT_TICK: begin
        if (tick_s) begin
          cnt_d   = A_ZERO;
          state_d = ERASE;
        end else begin
          state_d = WAIT_TICK;
        end
      end
      ERASE: begin
        px_wr_d = 1'b1;
        data_d  = C_BG;
        if (cnt_q == A_ZERO) begin
          addr_d = pix_addr(ball_x_q, ball_y_q);
        end else begin
          addr_d = pix_addr(pad_px(pad_x_q, cnt_q - A_ONE), PAD_ROW);
        end
        if (cnt_q == LAST_SPR) begin
          cnt_d   = A_ZERO;
          state_d = UPDATE;
        end else begin
          cnt_d = cnt_q + A_ONE;
        end
      end
      UPDATE: begin
        pad_x_d  = pad_new_s;
        ball_x_d = bx_new_s;
        ball_y_d = by_new_s;
        dir_x_d  = dx_s;
        dir_y_d  = dy_s;
        cnt_d    = A_ZERO;
`ifdef PONG_SCORE_EN
        if (hit_s) begin
          score_d  = (score_q != 8'hFF) ? (score_q + 8'd1) : score_q;
          period_d = (period_q >= (PER_FLOOR + PER_STEP)) ? (period_q - PER_STEP) : PER_FLOOR;
        end else begin
          score_d  = score_q;
          period_d = period_q;
        end
`endif
        if (lose_s) begin
          game_over_d = 1'b1;
          state_d     = LOST;
        end else begin
          state_d = DRAW;
        end
      end
      LOST: begin
        game_over_d = 1'b1;
        // cnt marks whether the centre marker has been written yet
        if (cnt_q == A_ZERO) begin
          px_wr_d = 1'b1;
          addr_d  = pix_addr(X_INIT, Y_INIT);
          data_d  = C_LOST;
          cnt_d   = A_ONE;
        end else if (btn_start) begin
          state_d     = CLEAR;
          cnt_d       = A_ZERO;
          ball_x_d    = X_INIT;
          ball_y_d    = Y_INIT;
          dir_x_d     = DIR_INC;
          dir_y_d     = DIR_INC;
          pad_x_d     = X_INIT;
          started_d   = 1'b0;
          game_over_d = 1'b0;
          busy_d      = 1'b1;
`ifdef PONG_SCORE_EN
          score_d     = 8'd0;
          period_d    = PER_INIT;
`endif
        end else begin
          state_d = LOST;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = A_ZERO;
        busy_d  = 1'b1;
      end
    endcase
  end

  // State, game and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      cnt_q       <= A_ZERO;
      ball_x_q    <= X_INIT;
      ball_y_q    <= Y_INIT;
      dir_x_q     <= DIR_INC;
      dir_y_q     <= DIR_INC;
      pad_x_q     <= X_INIT;
      started_q   <= 1'b0;
      px_wr_q     <= 1'b0;
      addr_q      <= A_ZERO;
      data_q      <= {DW{1'b0}};
      game_over_q <= 1'b0;
      busy_q      <= 1'b1;
`ifdef PONG_SCORE_EN
      score_q     <= 8'd0;
      period_q    <= PER_INIT;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      pad_x_q     <= pad_x_d;
      started_q   <= started_d;
      px_wr_q     <= px_wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      game_over_q <= game_over_d;
      busy_q      <= busy_d;
`ifdef PONG_SCORE_EN
      score_q     <= score_d;
      period_q    <= period_d;
`endif
    end
  end

  assign px_if.px_wr       = px_wr_q;
  assign px_if.mem_px_addr = addr_q;
  assign px_if.mem_px_data = data_q;
  assign game_over         = game_over_q;
  assign busy              = busy_q;
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: scoreboard bench; expected pixel writes are queued by the stimulus and popped by a monitor.
module tb_pong_engine;
  localparam int AW = 8;
  localparam int DW = 3;
  localparam logic [2:0] BG = 3'b001, PAD = 3'b010, BALL = 3'b111, LOSTC = 3'b100;

  logic clk = 1'b0;
  logic rst, btn_right, btn_left, btn_start, game_over, busy;
`ifdef PONG_SCORE_EN
  logic [7:0] score;
`endif

  pong_engine_if #(.AW(AW), .DW(DW)) px_if ();

  pong_engine #(.AW(AW), .DW(DW), .SCR_W(16), .SCR_H(12), .PAD_W(3), .PAD_Y(9), .TICK_DIV(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_right (btn_right),
    .btn_left  (btn_left),
    .btn_start (btn_start),
    .px_if     (px_if),
    .game_over (game_over),
    .busy      (busy)
`ifdef PONG_SCORE_EN
    ,
    .score     (score)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];

  // Per tick: new ball x, new ball y, new paddle x, buttons (0 none, 1 right, 2 left), lost
  int tbl [21][5] = '{
    '{ 9, 7, 8, 0, 0}, '{10, 8, 9, 1, 0}, '{11, 7,10, 1, 0}, '{12, 6, 9, 2, 0},
    '{13, 5, 8, 2, 0}, '{14, 4, 7, 2, 0}, '{15, 3, 6, 2, 0}, '{14, 2, 5, 2, 0},
    '{13, 1, 4, 2, 0}, '{12, 0, 3, 2, 0}, '{11, 1, 2, 2, 0}, '{10, 2, 1, 2, 0},
    '{ 9, 3, 1, 2, 0}, '{ 8, 4, 1, 0, 0}, '{ 7, 5, 1, 0, 0}, '{ 6, 6, 1, 0, 0},
    '{ 5, 7, 1, 0, 0}, '{ 4, 8, 1, 0, 0}, '{ 3, 9, 1, 0, 0}, '{ 2,10, 1, 0, 0},
    '{ 1,11, 1, 0, 1}
  };

  // Monitor: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (px_if.px_wr === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL px_unexpected actual addr=%0d data=%b required no write",
                 px_if.mem_px_addr, px_if.mem_px_data);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({px_if.mem_px_addr, px_if.mem_px_data} !== e) begin
          errors++;
          $display("FAIL px_write actual addr=%0d data=%b required addr=%0d data=%b",
                   px_if.mem_px_addr, px_if.mem_px_data, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic push_px(input int x, input int y, input logic [2:0] c);
    exp_q.push_back({AW'(y * 16 + x), c});
  endtask

  task automatic push_clear(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({AW'(i), BG});
  endtask

  task automatic push_draw(input int bx, input int by, input int px);
    for (int k = -1; k <= 1; k++) push_px(px + k, 9, PAD);
    push_px(bx, by, BALL);
  endtask

  task automatic wait_empty(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_start();
    btn_start = 1'b1;
    @(posedge clk);
    #1;
    btn_start = 1'b0;
  endtask

  initial begin
    int ox, oy, op, n;
    rst = 1'b1; btn_right = 1'b0; btn_left = 1'b0; btn_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_px_wr", int'(px_if.px_wr), 0);
    check("rst_addr", int'(px_if.mem_px_addr), 0);
    check("rst_data", int'(px_if.mem_px_data), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_game_over", int'(game_over), 0);
`ifdef PONG_SCORE_EN
    check("rst_score", int'(score), 0);
`endif

    // Initial clear and first render
    rst = 1'b0;
    push_clear(192);
    push_draw(8, 6, 8);
    @(posedge clk);
    #1;
    check("busy_in_clear", int'(busy), 1);
    wait_empty("clear0", 1000);
    check("busy_after_clear", int'(busy), 0);

    // Play through bounce, left clamp, miss and loss
    ox = 8; oy = 6; op = 8;
    for (int i = 0; i < 21; i++) begin
      btn_right = (tbl[i][3] == 1);
      btn_left  = (tbl[i][3] == 2);
      push_px(ox, oy, BG);
      for (int k = -1; k <= 1; k++) push_px(op + k, 9, BG);
      if (tbl[i][4] != 0) push_px(8, 6, LOSTC);
      else push_draw(tbl[i][0], tbl[i][1], tbl[i][2]);
      if (i == 0) pulse_start();
      wait_empty("tick", 300);
`ifdef PONG_SCORE_EN
      if (i == 2) check("score_bounce", int'(score), 1);
`endif
      if (i == 19) check("game_over_playing", int'(game_over), 0);
      ox = tbl[i][0]; oy = tbl[i][1]; op = tbl[i][2];
    end
    btn_right = 1'b0;
    btn_left  = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("game_over_lost", int'(game_over), 1);

    // Restart from LOST repeats the clear
    push_clear(192);
    push_draw(8, 6, 8);
    pulse_start();
    check("busy_restart", int'(busy), 1);
    check("game_over_restart", int'(game_over), 0);
    wait_empty("clear_restart", 1000);
    check("busy_restart_done", int'(busy), 0);
`ifdef PONG_SCORE_EN
    check("score_restart", int'(score), 0);
`endif

    // Reset in the middle of a clear
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("busy_rst_again", int'(busy), 1);
    rst = 1'b0;
    push_clear(51);
    n = 0;
    while (!(px_if.px_wr === 1'b1 && px_if.mem_px_addr == AW'(50)) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_addr50", int'(px_if.mem_px_addr), 50);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_clear_rst_px_wr", int'(px_if.px_wr), 0);
    check("mid_clear_rst_addr", int'(px_if.mem_px_addr), 0);
    rst = 1'b0;
    push_clear(192);
    push_draw(8, 6, 8);
    wait_empty("clear_after_rst", 1000);
    repeat (10) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
